// File: rtl/chan_select_pack.sv
// rtl/chan_select_pack.sv - channel selector and packetizer for the PFB channelizer output
// Drops masked-off channels and re-packs the kept samples into packets tagged with channel index.
module chan_select_pack #(
    parameter int NUM_CHAN_LOG2 = 5,
    parameter int SR_PKT_LEN    = 129,
    parameter int SR_MASK_BASE  = 130
) (
    input  logic                     ce_clk,
    input  logic                     ce_rst,
    input  logic                     set_stb,
    input  logic [7:0]               set_addr,
    input  logic [31:0]              set_data,
    input  logic [31:0]              i_tdata,
    input  logic                     i_tlast,
    input  logic                     i_tvalid,
    output logic                     i_tready,
    output logic [31:0]              o_tdata,
    output logic [NUM_CHAN_LOG2-1:0] o_tchan,
    output logic                     o_tlast,
    output logic                     o_tvalid,
    input  logic                     o_tready,
    output logic                     frame_err,
    output logic [NUM_CHAN_LOG2:0]   sel_count
);
    localparam int NUM_CHAN   = 1 << NUM_CHAN_LOG2;
    localparam int MASK_WORDS = (NUM_CHAN > 32) ? NUM_CHAN / 32 : 1;
    localparam int MW         = MASK_WORDS * 32;
    localparam logic [NUM_CHAN_LOG2-1:0] LAST_CHAN = NUM_CHAN_LOG2'(NUM_CHAN - 1);

    logic [MW-1:0]            stg_mask;
    logic [11:0]              stg_len;
    logic [NUM_CHAN-1:0]      mask;
    logic [11:0]              pkt_len;
    logic                     pending;
    logic [NUM_CHAN_LOG2-1:0] chan;
    logic [11:0]              pkt_cnt;

    logic                     len_wr;
    logic                     mask_wr;
    logic [MW-1:0]            mask_wr_data;
    logic                     hs_in;
    logic                     sel;
    logic                     frame_end;
    logic [NUM_CHAN-1:0]      above;
    logic                     last_sel;
    logic                     out_fire;
    logic                     out_last;
    logic [11:0]              cnt_next;
    logic                     load;

    function automatic logic [NUM_CHAN_LOG2:0] popcnt(input logic [NUM_CHAN-1:0] m);
        logic [NUM_CHAN_LOG2:0] c;
        c = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            c = c + {{NUM_CHAN_LOG2{1'b0}}, m[i]};
        end
        return c;
    endfunction

    always_comb begin
        len_wr       = set_stb && (set_addr == 8'(SR_PKT_LEN));
        mask_wr      = 1'b0;
        mask_wr_data = stg_mask;
        for (int k = 0; k < MASK_WORDS; k++) begin
            if (set_stb && (set_addr == 8'(SR_MASK_BASE + k))) begin
                mask_wr                  = 1'b1;
                mask_wr_data[32*k +: 32] = set_data;
            end
        end
    end

    assign i_tready  = ~o_tvalid | o_tready;
    assign hs_in     = i_tvalid & i_tready;
    assign sel       = mask[chan];
    assign frame_end = (chan == LAST_CHAN) | i_tlast;
    // Bits strictly above the current channel; none set means this is the frame's last kept sample.
    assign above     = ({NUM_CHAN{1'b1}} << chan) << 1;
    assign last_sel  = ~|(mask & above);
    assign out_fire  = hs_in & sel;
    assign out_last  = ((pkt_len != 12'd0) && (pkt_cnt == pkt_len - 12'd1)) ||
                       (((pkt_len == 12'd0) || pending) && last_sel);
    assign cnt_next  = out_fire ? (out_last ? 12'd0 : pkt_cnt + 12'd1) : pkt_cnt;
    // Config swaps only on a frame boundary with no packet left open.
    assign load      = hs_in & frame_end & pending & (cnt_next == 12'd0);

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            stg_mask  <= '1;
            stg_len   <= 12'd0;
            mask      <= '1;
            pkt_len   <= 12'd0;
            pending   <= 1'b0;
            sel_count <= (NUM_CHAN_LOG2 + 1)'(NUM_CHAN);
        end else begin
            if (len_wr) begin
                stg_len <= set_data[11:0];
            end
            if (mask_wr) begin
                stg_mask <= mask_wr_data;
            end
            if (load) begin
                mask      <= stg_mask[NUM_CHAN-1:0];
                pkt_len   <= stg_len;
                sel_count <= popcnt(stg_mask[NUM_CHAN-1:0]);
            end
            if (len_wr || mask_wr) begin
                pending <= 1'b1;
            end else if (load) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            chan      <= '0;
            pkt_cnt   <= 12'd0;
            frame_err <= 1'b0;
            o_tvalid  <= 1'b0;
            o_tlast   <= 1'b0;
            o_tdata   <= 32'd0;
            o_tchan   <= '0;
        end else begin
            frame_err <= hs_in & (i_tlast != (chan == LAST_CHAN));
            pkt_cnt   <= cnt_next;
            if (hs_in) begin
                chan <= frame_end ? '0 : chan + 1'b1;
            end
            if (out_fire) begin
                o_tvalid <= 1'b1;
                o_tdata  <= i_tdata;
                o_tchan  <= chan;
                o_tlast  <= out_last;
            end else if (o_tready) begin
                o_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_chan_select_pack.sv
// tb/tb_chan_select_pack.sv - scoreboard bench for chan_select_pack
// Reference model predicts each output at input acceptance; outputs are popped and compared on handshake.
module tb_chan_select_pack;
    localparam int NCL = 5;
    localparam int NC  = 32;

    logic           ce_clk = 1'b0;
    logic           ce_rst = 1'b1;
    logic           set_stb = 1'b0;
    logic [7:0]     set_addr = 8'd0;
    logic [31:0]    set_data = 32'd0;
    logic [31:0]    i_tdata = 32'd0;
    logic           i_tlast = 1'b0;
    logic           i_tvalid = 1'b0;
    logic           i_tready;
    logic [31:0]    o_tdata;
    logic [NCL-1:0] o_tchan;
    logic           o_tlast;
    logic           o_tvalid;
    logic           o_tready = 1'b1;
    logic           frame_err;
    logic [NCL:0]   sel_count;

    chan_select_pack #(.NUM_CHAN_LOG2(NCL), .SR_PKT_LEN(129), .SR_MASK_BASE(130)) dut (
        .ce_clk(ce_clk), .ce_rst(ce_rst),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tchan(o_tchan), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
        .o_tready(o_tready), .frame_err(frame_err), .sel_count(sel_count)
    );

    always #5 ce_clk = ~ce_clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] sbq[$];
    logic [31:0] m_mask, s_mask;
    logic [11:0] m_len, s_len, m_cnt;
    logic        m_pend;
    int          m_chan;
    logic        fe_exp;
    logic        prev_stall;
    logic [63:0] prev_out;
    logic        hs_flag;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mask = '1; s_mask = '1; m_len = 12'd0; s_len = 12'd0; m_cnt = 12'd0;
        m_pend = 1'b0; m_chan = 0; fe_exp = 1'b0; prev_stall = 1'b0; prev_out = 64'd0;
        sbq.delete();
    endtask

    task automatic cyc(input logic v, input logic [31:0] d, input logic l, input logic rdy,
                       input logic stb, input logic [7:0] a, input logic [31:0] sd);
        logic [63:0] cur;
        logic [31:0] above;
        logic        sel, lastsel, tl, fend;
        @(negedge ce_clk);
        i_tvalid = v; i_tdata = d; i_tlast = l; o_tready = rdy;
        set_stb = stb; set_addr = a; set_data = sd;
        #1;
        cur = 64'({o_tlast, o_tchan, o_tdata});
        if (prev_stall) begin
            check("hold_valid", 64'(o_tvalid), 64'd1);
            check("hold_data", cur, prev_out);
        end
        check("frame_err", 64'(frame_err), 64'(fe_exp));
        if (o_tvalid && o_tready) begin
            if (sbq.size() == 0) check("out_extra", 64'(sbq.size()), 64'd1);
            else check("out", cur, sbq.pop_front());
        end
        prev_stall = o_tvalid && !o_tready;
        prev_out   = cur;
        hs_flag    = v && i_tready;
        fe_exp     = 1'b0;
        if (hs_flag) begin
            fend    = (m_chan == NC - 1) || l;
            fe_exp  = l != (m_chan == NC - 1);
            sel     = m_mask[m_chan];
            above   = (m_chan == NC - 1) ? 32'd0 : (32'hFFFF_FFFF << (m_chan + 1));
            lastsel = (m_mask & above) == 32'd0;
            if (sel) begin
                tl = ((m_len != 12'd0) && (m_cnt == m_len - 12'd1)) ||
                     (((m_len == 12'd0) || m_pend) && lastsel);
                sbq.push_back(64'({tl, 5'(m_chan), d}));
                m_cnt = tl ? 12'd0 : m_cnt + 12'd1;
            end
            if (fend && m_pend && (m_cnt == 12'd0)) begin
                m_mask = s_mask; m_len = s_len; m_pend = 1'b0;
            end
            m_chan = fend ? 0 : m_chan + 1;
        end
        if (stb && a == 8'd129) begin s_len = sd[11:0]; m_pend = 1'b1; end
        if (stb && a == 8'd130) begin s_mask = sd; m_pend = 1'b1; end
    endtask

    // mode 0: tlast on channel 31; mode 1: tlast on last sample of this call; mode 2: never
    task automatic feed(input int n, input int fid, input int mode,
                        input logic stb, input logic [7:0] a, input logic [31:0] sd);
        logic l;
        for (int i = 0; i < n; i++) begin
            l = (mode == 0) ? (m_chan == NC - 1) : (mode == 1) ? (i == n - 1) : 1'b0;
            cyc(1'b1, {16'(fid), 16'(m_chan)}, l, 1'b1, stb && (i == 0), a, sd);
            check("feed_hs", 64'(hs_flag), 64'd1);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((sbq.size() != 0 || o_tvalid) && g < 200) begin
            cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 8'd0, 32'd0);
            g++;
        end
        check("drain_left", 64'(sbq.size()), 64'd0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] sd);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, a, sd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, guard;
        model_reset();
        repeat (2) @(negedge ce_clk);
        check("rst_tvalid", 64'(o_tvalid), 64'd0);
        check("rst_tlast", 64'(o_tlast), 64'd0);
        check("rst_tdata", 64'(o_tdata), 64'd0);
        check("rst_tchan", 64'(o_tchan), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_sel_count", 64'(sel_count), 64'd32);
        check("rst_tready", 64'(i_tready), 64'd1);
        ce_rst = 1'b0;

        // defaults: all channels, one packet per frame
        feed(32, 0, 0, 1'b0, 8'd0, 32'd0);
        feed(32, 1, 0, 1'b0, 8'd0, 32'd0);
        drain();
        check("sel_count_t1", 64'(sel_count), 64'd32);

        // sparse mask, frame mode; first frame after the write flushes and loads
        wr(8'd130, 32'h0000_8005);
        feed(32, 2, 0, 1'b0, 8'd0, 32'd0);
        feed(32, 3, 0, 1'b0, 8'd0, 32'd0);
        feed(32, 4, 0, 1'b0, 8'd0, 32'd0);
        drain();
        check("sel_count_t2", 64'(sel_count), 64'd3);

        // fixed packet length crossing frame boundaries
        wr(8'd129, 32'd5);
        wr(8'd130, 32'hFFFF_FFFF);
        feed(32, 5, 0, 1'b0, 8'd0, 32'd0);
        feed(32, 6, 0, 1'b0, 8'd0, 32'd0);
        feed(32, 7, 0, 1'b0, 8'd0, 32'd0);
        feed(32, 8, 0, 1'b0, 8'd0, 32'd0);
        drain();
        check("sel_count_t3", 64'(sel_count), 64'd32);

        // mid-packet reconfiguration at channel 12
        feed(12, 9, 0, 1'b0, 8'd0, 32'd0);
        feed(1, 9, 0, 1'b1, 8'd130, 32'h0000_0003);
        feed(1, 9, 0, 1'b1, 8'd129, 32'd0);
        feed(18, 9, 0, 1'b0, 8'd0, 32'd0);
        feed(32, 10, 0, 1'b0, 8'd0, 32'd0);
        feed(32, 11, 0, 1'b0, 8'd0, 32'd0);
        drain();
        check("sel_count_t4", 64'(sel_count), 64'd2);

        // early tlast, then missing tlast
        feed(11, 12, 1, 1'b0, 8'd0, 32'd0);
        feed(32, 13, 0, 1'b0, 8'd0, 32'd0);
        feed(32, 14, 2, 1'b0, 8'd0, 32'd0);
        feed(32, 15, 0, 1'b0, 8'd0, 32'd0);
        drain();

        // random valid gaps and backpressure with a pending reconfiguration
        wr(8'd129, 32'd7);
        wr(8'd130, 32'hF0F0_1234);
        sent = 0;
        guard = 0;
        while (sent < 300 && guard < 5000) begin
            cyc(1'($urandom_range(0, 1)), {16'(sent), 16'(m_chan)}, m_chan == NC - 1,
                1'($urandom_range(0, 1)), 1'b0, 8'd0, 32'd0);
            if (hs_flag) sent++;
            guard++;
        end
        check("rand_sent", 64'(sent), 64'd300);
        drain();
        check("sel_count_t6", 64'(sel_count), 64'($countones(m_mask)));

        // reset while an output is stalled
        cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        check("stall_tvalid", 64'(o_tvalid), 64'd1);
        #2;
        ce_rst = 1'b1;
        #1;
        check("rst_async_tvalid", 64'(o_tvalid), 64'd0);
        i_tvalid = 1'b0;
        model_reset();
        repeat (2) @(negedge ce_clk);
        ce_rst = 1'b0;
        check("rst2_sel_count", 64'(sel_count), 64'd32);
        feed(32, 16, 0, 1'b0, 8'd0, 32'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
